// File: rtl/circ_fifo_mon.sv
`default_nettype none
// ============================================================================
// Module   : circ_fifo_mon
// Purpose  : Single-clock circular FIFO with occupancy and throughput
//            statistics: almost-full/almost-empty thresholds, high-water
//            mark, rejected-write/read pulses and saturating event counters,
//            synchronous flush and synchronous statistics clear.
// Ports    : clk_i          - clock, rising edge
//            rst_ni         - asynchronous active-low reset
//            wr_en_i/data_i - write request and data
//            rd_en_i/data_o - read request, registered read data
//            flush_i        - discard contents (statistics kept)
//            clr_stats_i    - clear counters, reload high-water mark
//            full_o/empty_o/almost_full_o/almost_empty_o - decodes of count_o
//            count_o        - current occupancy 0..DEPTH
//            max_count_o    - high-water mark
//            overflow_o/underflow_o - one-cycle pulses after a reject
//            ovf_cnt_o/udf_cnt_o    - saturating reject counters
// Revision : 1.0 - initial release
// ============================================================================
module circ_fifo_mon #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH_W = 2,
    parameter int AF_THRESH    = 3,
    parameter int AE_THRESH    = 1,
    parameter int CNT_W        = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    rd_en_i,
    output logic [DATA_W-1:0]       data_o,
    input  logic                    flush_i,
    input  logic                    clr_stats_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    almost_full_o,
    output logic                    almost_empty_o,
    output logic [FIFO_DEPTH_W:0]   count_o,
    output logic [FIFO_DEPTH_W:0]   max_count_o,
    output logic                    overflow_o,
    output logic                    underflow_o,
    output logic [CNT_W-1:0]        ovf_cnt_o,
    output logic [CNT_W-1:0]        udf_cnt_o
);

    localparam int                   c_DEPTH     = 2 ** FIFO_DEPTH_W;
    localparam logic [FIFO_DEPTH_W:0] c_DEPTH_CNT = (FIFO_DEPTH_W+1)'(c_DEPTH);
    localparam logic [FIFO_DEPTH_W:0] c_AF_CNT    = (FIFO_DEPTH_W+1)'(AF_THRESH);
    localparam logic [FIFO_DEPTH_W:0] c_AE_CNT    = (FIFO_DEPTH_W+1)'(AE_THRESH);
    localparam logic [CNT_W-1:0]      c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [FIFO_DEPTH_W-1:0] c_PTR_ONE = FIFO_DEPTH_W'(1);
    localparam logic [FIFO_DEPTH_W:0] c_CNT_ONE   = (FIFO_DEPTH_W+1)'(1);

    // Illegal thresholds stop elaboration rather than silently misbehaving.
    if (AF_THRESH < 1 || AF_THRESH > c_DEPTH) begin : g_bad_af_thresh
        $fatal(1, "circ_fifo_mon: AF_THRESH=%0d out of range 1..%0d", AF_THRESH, c_DEPTH);
    end
    if (AE_THRESH < 0 || AE_THRESH > c_DEPTH - 1) begin : g_bad_ae_thresh
        $fatal(1, "circ_fifo_mon: AE_THRESH=%0d out of range 0..%0d", AE_THRESH, c_DEPTH - 1);
    end
    if (DATA_W < 1 || FIFO_DEPTH_W < 1 || CNT_W < 1) begin : g_bad_widths
        $fatal(1, "circ_fifo_mon: DATA_W, FIFO_DEPTH_W and CNT_W must be >= 1");
    end

    logic [DATA_W-1:0]       r_mem [c_DEPTH];
    logic [FIFO_DEPTH_W-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_W-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_W:0]   r_count;
    logic [FIFO_DEPTH_W:0]   r_max_count;
    logic [DATA_W-1:0]       r_data;
    logic                    r_overflow;
    logic                    r_underflow;
    logic [CNT_W-1:0]        r_ovf_cnt;
    logic [CNT_W-1:0]        r_udf_cnt;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_wr_acc;
    logic                    w_rd_acc;
    logic                    w_wr_rej;
    logic                    w_rd_rej;
    logic [FIFO_DEPTH_W:0]   w_count_nxt;

    // Flags come only from the registered count, never from this cycle's requests.
    assign w_full  = (r_count == c_DEPTH_CNT);
    assign w_empty = (r_count == '0);

    // A flush swallows both requests: nothing is accepted and nothing is a reject.
    assign w_wr_acc = wr_en_i & ~w_full  & ~flush_i;
    assign w_rd_acc = rd_en_i & ~w_empty & ~flush_i;
    assign w_wr_rej = wr_en_i &  w_full  & ~flush_i;
    assign w_rd_rej = rd_en_i &  w_empty & ~flush_i;

    always_comb begin
        w_count_nxt = r_count;
        if (flush_i) begin
            w_count_nxt = '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_count_nxt = r_count + c_CNT_ONE;
                2'b01:   w_count_nxt = r_count - c_CNT_ONE;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Storage is not reset; occupancy is tracked by r_count alone.
    always_ff @(posedge clk_i) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_max_count <= '0;
            r_data      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_ovf_cnt   <= '0;
            r_udf_cnt   <= '0;
        end else begin
            r_count     <= w_count_nxt;
            r_overflow  <= w_wr_rej;
            r_underflow <= w_rd_rej;

            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                    r_data   <= r_mem[r_rd_ptr];
                end
            end

            // Clearing statistics restarts the high-water mark from the new occupancy.
            if (clr_stats_i) begin
                r_max_count <= w_count_nxt;
            end else if (w_count_nxt > r_max_count) begin
                r_max_count <= w_count_nxt;
            end

            if (clr_stats_i) begin
                r_ovf_cnt <= '0;
                r_udf_cnt <= '0;
            end else begin
                if (w_wr_rej && r_ovf_cnt != c_CNT_MAX) begin
                    r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
                end
                if (w_rd_rej && r_udf_cnt != c_CNT_MAX) begin
                    r_udf_cnt <= r_udf_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign almost_full_o  = (r_count >= c_AF_CNT);
    assign almost_empty_o = (r_count <= c_AE_CNT);
    assign count_o        = r_count;
    assign max_count_o    = r_max_count;
    assign data_o         = r_data;
    assign overflow_o     = r_overflow;
    assign underflow_o    = r_underflow;
    assign ovf_cnt_o      = r_ovf_cnt;
    assign udf_cnt_o      = r_udf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_circ_fifo_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_circ_fifo_mon
// Purpose  : Directed self-checking bench for circ_fifo_mon (DEPTH=4) plus a
//            second instance with 2-bit counters for saturation.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_circ_fifo_mon;

    logic       clk;
    logic       rst_n;
    logic       wr_en, rd_en, flush, clr_stats;
    logic [7:0] din, dout;
    logic       full, empty, afull, aempty, ovf, udf;
    logic [2:0] count, max_count;
    logic [15:0] ovf_cnt, udf_cnt;

    logic       rd_en2;
    logic       wr_en2, flush2, clr2;
    logic [7:0] din2, dout2;
    logic       full2, empty2, afull2, aempty2, ovf2, udf2;
    logic [2:0] count2, max2;
    logic [1:0] ovf_cnt2, udf_cnt2;

    int checks = 0;
    int errors = 0;

    circ_fifo_mon #(.DATA_W(8), .FIFO_DEPTH_W(2), .AF_THRESH(3), .AE_THRESH(1), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .data_i(din), .rd_en_i(rd_en),
        .data_o(dout), .flush_i(flush), .clr_stats_i(clr_stats), .full_o(full),
        .empty_o(empty), .almost_full_o(afull), .almost_empty_o(aempty), .count_o(count),
        .max_count_o(max_count), .overflow_o(ovf), .underflow_o(udf),
        .ovf_cnt_o(ovf_cnt), .udf_cnt_o(udf_cnt)
    );

    circ_fifo_mon #(.DATA_W(8), .FIFO_DEPTH_W(2), .AF_THRESH(3), .AE_THRESH(1), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en2), .data_i(din2), .rd_en_i(rd_en2),
        .data_o(dout2), .flush_i(flush2), .clr_stats_i(clr2), .full_o(full2),
        .empty_o(empty2), .almost_full_o(afull2), .almost_empty_o(aempty2), .count_o(count2),
        .max_count_o(max2), .overflow_o(ovf2), .underflow_o(udf2),
        .ovf_cnt_o(ovf_cnt2), .udf_cnt_o(udf_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 0; rd_en = 0; flush = 0; clr_stats = 0; din = 8'h00;
        rd_en2 = 0; wr_en2 = 0; flush2 = 0; clr2 = 0; din2 = 8'h00;
        tick(); tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (aempty !== 1'b1 || afull !== 1'b0) begin errors++; $display("FAIL reset_almost: got ae=%b af=%b expected ae=1 af=0", aempty, afull); end
        checks++; if (count !== 3'd0 || max_count !== 3'd0) begin errors++; $display("FAIL reset_count: got count=%0d max=%0d expected 0 0", count, max_count); end
        checks++; if (dout !== 8'h00 || ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL reset_data: got data=%h ovf=%b udf=%b expected 00 0 0", dout, ovf, udf); end
        checks++; if (ovf_cnt !== 16'd0 || udf_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnts: got %0d %0d expected 0 0", ovf_cnt, udf_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        logic [2:0] exp_cnt;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; din = 8'hA1 + 8'(i);
            tick();
            exp_cnt = 3'(i + 1);
            checks++; if (count !== exp_cnt) begin errors++; $display("FAIL fill_count: got %0d expected %0d", count, exp_cnt); end
            checks++; if (afull !== (i >= 2)) begin errors++; $display("FAIL fill_afull: got %b expected %b at count %0d", afull, (i >= 2), exp_cnt); end
            checks++; if (full !== (i == 3)) begin errors++; $display("FAIL fill_full: got %b expected %b at count %0d", full, (i == 3), exp_cnt); end
            checks++; if (aempty !== (i == 0)) begin errors++; $display("FAIL fill_aempty: got %b expected %b at count %0d", aempty, (i == 0), exp_cnt); end
        end
        wr_en = 0;
        for (int i = 0; i < 4; i++) begin
            rd_en = 1;
            tick();
            exp_cnt = 3'(3 - i);
            checks++; if (dout !== 8'hA1 + 8'(i)) begin errors++; $display("FAIL drain_data: got %h expected %h", dout, 8'hA1 + 8'(i)); end
            checks++; if (count !== exp_cnt) begin errors++; $display("FAIL drain_count: got %0d expected %0d", count, exp_cnt); end
        end
        rd_en = 0;
        tick();
        checks++; if (empty !== 1'b1 || dout !== 8'hA4) begin errors++; $display("FAIL drain_end: got empty=%b data=%h expected 1 a4", empty, dout); end
        checks++; if (max_count !== 3'd4) begin errors++; $display("FAIL drain_max: got %0d expected 4", max_count); end
    endtask

    task automatic test_back_to_back();
        wr_en = 1; din = 8'h10;
        tick();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1; rd_en = 1; din = 8'h11 + 8'(i);
            tick();
            checks++; if (dout !== 8'h10 + 8'(i)) begin errors++; $display("FAIL b2b_data: got %h expected %h", dout, 8'h10 + 8'(i)); end
            checks++; if (count !== 3'd1 || ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL b2b_state: got count=%0d ovf=%b udf=%b expected 1 0 0", count, ovf, udf); end
        end
        wr_en = 0; rd_en = 1;
        tick();
        rd_en = 0;
        checks++; if (dout !== 8'h1A || count !== 3'd0) begin errors++; $display("FAIL b2b_last: got data=%h count=%0d expected 1a 0", dout, count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; din = 8'hB0 + 8'(i);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; din = 8'hEE;
            tick();
            checks++; if (ovf !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL ovf_pulse: got ovf=%b count=%0d expected 1 4", ovf, count); end
        end
        wr_en = 0;
        tick();
        checks++; if (ovf !== 1'b0 || ovf_cnt !== 16'd3) begin errors++; $display("FAIL ovf_cnt3: got ovf=%b cnt=%0d expected 0 3", ovf, ovf_cnt); end
        wr_en = 1; rd_en = 1; din = 8'hEF;
        tick();
        wr_en = 0; rd_en = 0;
        checks++; if (count !== 3'd3 || dout !== 8'hB0 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_wrrd: got count=%0d data=%h ovf=%b expected 3 b0 1", count, dout, ovf); end
        tick();
        checks++; if (ovf_cnt !== 16'd4) begin errors++; $display("FAIL ovf_cnt4: got %0d expected 4", ovf_cnt); end
        for (int i = 1; i < 4; i++) begin
            rd_en = 1;
            tick();
            checks++; if (dout !== 8'hB0 + 8'(i)) begin errors++; $display("FAIL ovf_contents: got %h expected %h", dout, 8'hB0 + 8'(i)); end
        end
        rd_en = 0;
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b expected 1", empty); end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 2; i++) begin
            rd_en = 1;
            tick();
            checks++; if (udf !== 1'b1 || dout !== 8'hB3) begin errors++; $display("FAIL udf_pulse: got udf=%b data=%h expected 1 b3", udf, dout); end
        end
        rd_en = 0;
        tick();
        checks++; if (udf !== 1'b0 || udf_cnt !== 16'd2) begin errors++; $display("FAIL udf_cnt: got udf=%b cnt=%0d expected 0 2", udf, udf_cnt); end
        for (int i = 0; i < 5; i++) begin
            rd_en2 = 1;
            tick();
        end
        rd_en2 = 0;
        tick();
        checks++; if (udf_cnt2 !== 2'd3) begin errors++; $display("FAIL udf_saturate: got %0d expected 3", udf_cnt2); end
    endtask

    task automatic test_flush();
        clr_stats = 1;
        tick();
        clr_stats = 0;
        checks++; if (max_count !== 3'd0 || ovf_cnt !== 16'd0 || udf_cnt !== 16'd0) begin errors++; $display("FAIL preclr: got max=%0d ovf=%0d udf=%0d expected 0 0 0", max_count, ovf_cnt, udf_cnt); end
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; din = 8'hC0 + 8'(i);
            tick();
        end
        flush = 1; wr_en = 1; din = 8'hCC;
        tick();
        flush = 0; wr_en = 0;
        checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_count: got count=%0d empty=%b expected 0 1", count, empty); end
        checks++; if (max_count !== 3'd3 || dout !== 8'hB3) begin errors++; $display("FAIL flush_hold: got max=%0d data=%h expected 3 b3", max_count, dout); end
        tick();
        checks++; if (ovf !== 1'b0 || ovf_cnt !== 16'd0) begin errors++; $display("FAIL flush_noovf: got ovf=%b cnt=%0d expected 0 0", ovf, ovf_cnt); end
        clr_stats = 1;
        tick();
        clr_stats = 0;
        checks++; if (max_count !== 3'd0 || ovf_cnt !== 16'd0 || udf_cnt !== 16'd0) begin errors++; $display("FAIL clr_stats: got max=%0d ovf=%0d udf=%0d expected 0 0 0", max_count, ovf_cnt, udf_cnt); end
        wr_en = 1; din = 8'hD5;
        tick();
        wr_en = 0; rd_en = 1;
        tick();
        rd_en = 0;
        checks++; if (dout !== 8'hD5 || count !== 3'd0) begin errors++; $display("FAIL flush_reuse: got data=%h count=%0d expected d5 0", dout, count); end
    endtask

    task automatic test_async_reset();
        wr_en = 1; din = 8'h71;
        tick();
        din = 8'h72;
        tick();
        wr_en = 0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL arst_count: got count=%0d empty=%b full=%b expected 0 1 0", count, empty, full); end
        checks++; if (dout !== 8'h00 || max_count !== 3'd0) begin errors++; $display("FAIL arst_data: got data=%h max=%0d expected 00 0", dout, max_count); end
        tick();
        rst_n = 1'b1;
        tick();
        wr_en = 1; din = 8'h5A;
        tick();
        wr_en = 0; rd_en = 1;
        tick();
        rd_en = 0;
        checks++; if (dout !== 8'h5A || count !== 3'd0) begin errors++; $display("FAIL arst_roundtrip: got data=%h count=%0d expected 5a 0", dout, count); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/circ_fifo_mon.md
Name: circ_fifo_mon

Overview:
Parametrised single-clock circular FIFO with built-in occupancy and throughput statistics. It generalises the 1-bit sync buffer used in buffer-size estimation benches. It adds a configurable data width, programmable almost-full/almost-empty thresholds, a high-water mark, saturating overflow/underflow event counters, and a synchronous flush. It sits between a producer and a consumer in throughput benches and in designs that need run-time buffer sizing data.

Parameters:
DATA_W, 8, data word width in bits (>=1)
FIFO_DEPTH_W, 2, log2 of depth; DEPTH = 2**FIFO_DEPTH_W (>=1)
AF_THRESH, 3, almost_full_o asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty_o asserts when count <= AE_THRESH (0..DEPTH-1)
CNT_W, 16, width of the overflow/underflow event counters

Ports:
clk_i  in  1  single clock; all logic on rising edge
rst_ni  in  1  asynchronous active-low reset
wr_en_i  in  1  write request
data_i  in  DATA_W  write data
rd_en_i  in  1  read request
data_o  out  DATA_W  read data, registered
flush_i  in  1  synchronous flush of contents
clr_stats_i  in  1  synchronous clear of statistics
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
almost_full_o  out  1  count >= AF_THRESH
almost_empty_o  out  1  count <= AE_THRESH
count_o  out  FIFO_DEPTH_W+1  current occupancy 0..DEPTH
max_count_o  out  FIFO_DEPTH_W+1  high-water mark
overflow_o  out  1  one-cycle pulse, rejected write
underflow_o  out  1  one-cycle pulse, rejected read
ovf_cnt_o  out  CNT_W  saturating count of rejected writes
udf_cnt_o  out  CNT_W  saturating count of rejected reads

Behaviour:
- Reset (async assert, sync release):
  - pointers, count, max_count, both counters and data_o = 0
  - overflow_o and underflow_o = 0
  - empty_o=1, full_o=0, almost_empty_o=1 (AE_THRESH>=0), almost_full_o=0
  - Reset mid-operation discards contents immediately.
- Status flags are combinational decodes of the registered count. They never depend on same-cycle requests.
- Write accepted iff wr_en_i & ~full_o & ~flush_i. Read accepted iff rd_en_i & ~empty_o & ~flush_i.
- Full with both requested: read accepted, write rejected (overflow). Empty with both requested: write accepted, read rejected (underflow). No fall-through.
- Both accepted: count unchanged, both pointers advance.
- Pointers are FIFO_DEPTH_W bits and wrap DEPTH-1 -> 0 naturally. count tracks occupancy separately.
- Read latency 1: data_o updates on the edge after an accepted read and holds until the next accepted read. Rejected reads leave data_o unchanged.
- Order strictly FIFO across arbitrary wrap counts.
- overflow_o/underflow_o: registered pulses, high for exactly the cycle after the rejected request. Back-to-back rejects give a continuous high.
- ovf_cnt_o/udf_cnt_o: +1 per rejected request, saturate at 2**CNT_W-1 (no wrap).
- max_count_o <= max(max_count_o, next count) every cycle.
- clr_stats_i:
  - counters go to 0
  - max_count_o goes to the next count
  - same-cycle reject events are not counted, but their pulses still fire
  - does not affect FIFO contents
- flush_i:
  - pointers and count go to 0 next cycle; data_o is held
  - same-cycle wr/rd are ignored and not counted as overflow/underflow
  - statistics are not cleared; max_count_o keeps its value
- Threshold legality is checked at elaboration. Out-of-range values are a fatal elaboration error.

Test Plan:
- Fill DEPTH=4 with 0xA1..0xA4, then read 4: data_o = A1,A2,A3,A4, each one cycle after its read. count_o 0->4->0. full_o at 4, almost_full_o from count 3, empty_o at 0. max_count_o=4.
- 10 write/read cycles, simultaneous after one pre-fill: count_o stays 1, pointers wrap twice, output order preserved, no overflow/underflow pulses.
- When full, assert wr_en_i for 3 cycles: data unchanged, overflow_o high 3 cycles (delayed by 1), ovf_cnt_o=3. When full, wr+rd together: read accepted, ovf_cnt_o=4, count_o=3.
- Read when empty for 2 cycles: underflow_o pulses, udf_cnt_o=2, data_o holds its last value. With CNT_W=2, 5 rejects give udf_cnt_o saturated at 3.
- Fill to 3, flush_i with wr_en_i high: next cycle count_o=0, empty_o=1, no overflow counted, max_count_o=3. Then clr_stats_i gives max_count_o=0 and counters 0.
- Assert rst_ni low mid-fill, asynchronously between edges: all outputs reach their reset values before the next edge. After release, a first write/read round-trip is correct.
